// File: rtl/result_addr_ring_if.sv
// Interface bundling the allocation request/release controls and the ring status outputs.
// master drives inc_addr/rel_slot/clr_overflow; slave (the ring) drives address and status.
interface result_addr_ring_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 3
);
    logic              inc_addr;
    logic              rel_slot;
    logic              clr_overflow;
    logic [ADDR_W-1:0] addr_out;
    logic              write_enable;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [CNT_W-1:0]  slot_count;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output inc_addr, rel_slot, clr_overflow,
        input  addr_out, write_enable, rd_addr_out,
        input  slot_count, full, empty, overflow
    );

    modport slave (
        input  inc_addr, rel_slot, clr_overflow,
        output addr_out, write_enable, rd_addr_out,
        output slot_count, full, empty, overflow
    );
endinterface

// File: rtl/result_addr_ring.sv
// Circular result-slot allocator: NUM_SLOTS slots of STRIDE bytes from BASE_ADDR,
// one write_enable strobe per accepted allocation, occupancy tracking and sticky overflow.
// Ports: clk, rst (sync, active-high), bus (result_addr_ring_if.slave):
//   in  inc_addr, rel_slot, clr_overflow
//   out addr_out, write_enable, rd_addr_out, slot_count, full, empty, overflow
// Build option: define RESULT_ADDR_OVERWRITE_EN to let an allocation while full
// overwrite the oldest slot instead of being dropped.
module result_addr_ring #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] STRIDE    = 32'h0000_060E,
    parameter int              NUM_SLOTS = 4,
    parameter int              CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input logic               clk,
    input logic               rst,
    result_addr_ring_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SLOTS);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  wr_idx, wr_idx_next;
    logic [IDX_W-1:0]  rd_idx, rd_idx_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [ADDR_W-1:0] rd_addr, rd_addr_next;
    logic [CNT_W-1:0]  count, count_next;
    logic              full, full_next;
    logic              empty, empty_next;
    logic              overflow, overflow_next;

    logic inc_acc;
    logic rel_ok;
    logic drop;
    logic ovf_evt;

    // Acceptance uses the registered full flag, so a release in the same
    // cycle cannot make room for a concurrent allocation.
`ifdef RESULT_ADDR_OVERWRITE_EN
    assign inc_acc = bus.inc_addr;
    assign drop    = bus.inc_addr & full;
`else
    assign inc_acc = bus.inc_addr & ~full;
    assign drop    = 1'b0;
`endif
    assign rel_ok  = bus.rel_slot & ~empty;
    assign ovf_evt = bus.inc_addr & full;

    always_comb begin
        state_next    = inc_acc ? WRITE : IDLE;
        wr_idx_next   = wr_idx;
        addr_next     = addr;
        rd_idx_next   = rd_idx;
        rd_addr_next  = rd_addr;
        count_next    = count;
        overflow_next = overflow;

        if (inc_acc) begin
            if (wr_idx == LAST_IDX) begin
                wr_idx_next = '0;
                addr_next   = BASE_ADDR;
            end else begin
                wr_idx_next = wr_idx + IDX_W'(1);
                addr_next   = addr + STRIDE;
            end
        end

        // An overwrite discards the oldest slot; with a release in the
        // same cycle the read side still advances only once.
        if (rel_ok || drop) begin
            if (rd_idx == LAST_IDX) begin
                rd_idx_next  = '0;
                rd_addr_next = BASE_ADDR;
            end else begin
                rd_idx_next  = rd_idx + IDX_W'(1);
                rd_addr_next = rd_addr + STRIDE;
            end
        end

        if (inc_acc && !rel_ok && !drop) begin
            count_next = count + CNT_W'(1);
        end else if (!inc_acc && rel_ok) begin
            count_next = count - CNT_W'(1);
        end else if (drop && rel_ok) begin
            count_next = count - CNT_W'(1);
        end

        // Set has priority over clear.
        if (ovf_evt) begin
            overflow_next = 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_next = 1'b0;
        end

        full_next  = (count_next == CNT_FULL);
        empty_next = (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_idx   <= '0;
            addr     <= BASE_ADDR;
            rd_idx   <= IDX_W'(1);
            rd_addr  <= BASE_ADDR + STRIDE;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            wr_idx   <= wr_idx_next;
            addr     <= addr_next;
            rd_idx   <= rd_idx_next;
            rd_addr  <= rd_addr_next;
            count    <= count_next;
            full     <= full_next;
            empty    <= empty_next;
            overflow <= overflow_next;
        end
    end

    assign bus.addr_out     = addr;
    assign bus.write_enable = (state == WRITE);
    assign bus.rd_addr_out  = rd_addr;
    assign bus.slot_count   = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.overflow     = overflow;
endmodule

// File: tb/tb_result_addr_ring.sv
// Self-checking bench for result_addr_ring: directed literal checks plus
// randomized traffic compared every cycle against a slot-arithmetic model.
module tb_result_addr_ring;
    localparam int          N      = 4;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] STRIDE = 32'h0000_060E;
`ifdef RESULT_ADDR_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    result_addr_ring_if #(.ADDR_W(32), .CNT_W(3)) bus ();

    result_addr_ring #(
        .ADDR_W(32), .BASE_ADDR(BASE), .STRIDE(STRIDE), .NUM_SLOTS(N), .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: slot address is BASE + idx*STRIDE; indices are plain modular counters.
    int m_wr, m_rd, m_cnt;
    bit m_we, m_ovf, m_valid;

    function automatic logic [31:0] slot_addr(input int idx);
        longint a;
        a = longint'(BASE) + longint'(idx) * longint'(STRIDE);
        return a[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit full_now, acc, rv, drop;
        if (rst) begin
            m_wr = 0; m_rd = 1; m_cnt = 0; m_we = 0; m_ovf = 0; m_valid = 1;
        end else if (m_valid) begin
            full_now = (m_cnt == N);
            acc  = bus.inc_addr && (!full_now || OVW);
            rv   = bus.rel_slot && (m_cnt != 0);
            drop = OVW && bus.inc_addr && full_now;
            m_we = acc;
            if (acc) m_wr = (m_wr + 1) % N;
            if (rv || drop) m_rd = (m_rd + 1) % N;
            m_cnt = m_cnt + int'(acc) - int'(rv) - int'(drop);
            if (bus.inc_addr && full_now) m_ovf = 1;
            else if (bus.clr_overflow) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("addr_out", bus.addr_out, slot_addr(m_wr));
            chk("write_enable", 32'(bus.write_enable), 32'(m_we));
            chk("rd_addr_out", bus.rd_addr_out, slot_addr(m_rd));
            chk("slot_count", 32'(bus.slot_count), 32'(m_cnt));
            chk("full", 32'(bus.full), 32'(m_cnt == N));
            chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    task automatic cyc(input bit i, input bit r, input bit c);
        bus.inc_addr     = i;
        bus.rel_slot     = r;
        bus.clr_overflow = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_valid = 0;
        rst = 1'b1;
        bus.inc_addr = 0;
        bus.rel_slot = 0;
        bus.clr_overflow = 0;
        do_reset();

        chk("rst addr", bus.addr_out, 32'h0000);
        chk("rst we", 32'(bus.write_enable), 0);
        chk("rst empty", 32'(bus.empty), 1);
        chk("rst rd_addr", bus.rd_addr_out, 32'h060E);
        chk("rst count", 32'(bus.slot_count), 0);

`ifndef RESULT_ADDR_OVERWRITE_EN
        cyc(1, 0, 0); chk("w1 addr", bus.addr_out, 32'h060E); chk("w1 we", 32'(bus.write_enable), 1);
        cyc(0, 0, 0); chk("gap we", 32'(bus.write_enable), 0);
        cyc(1, 0, 0); chk("w2 addr", bus.addr_out, 32'h0C1C);
        cyc(0, 0, 0);
        cyc(1, 0, 0); chk("w3 addr", bus.addr_out, 32'h122A);
        cyc(0, 0, 0);
        cyc(1, 0, 0); chk("w4 addr", bus.addr_out, 32'h0000); chk("w4 we", 32'(bus.write_enable), 1);
        cyc(0, 0, 0); chk("full", 32'(bus.full), 1); chk("count4", 32'(bus.slot_count), 4);
        cyc(1, 0, 0);
        chk("ovf we", 32'(bus.write_enable), 0);
        chk("ovf addr", bus.addr_out, 32'h0000);
        chk("ovf set", 32'(bus.overflow), 1);
        cyc(0, 0, 1); chk("ovf clr", 32'(bus.overflow), 0);
        cyc(0, 1, 0); chk("rel1 rd", bus.rd_addr_out, 32'h0C1C);
        cyc(0, 1, 0); chk("rel2 rd", bus.rd_addr_out, 32'h122A); chk("rel2 cnt", 32'(bus.slot_count), 2);
        cyc(1, 1, 0);
        chk("both addr", bus.addr_out, 32'h060E);
        chk("both rd", bus.rd_addr_out, 32'h0000);
        chk("both cnt", 32'(bus.slot_count), 2);
        cyc(0, 0, 0);

        do_reset();
        cyc(1, 0, 0); chk("b1 addr", bus.addr_out, 32'h060E); chk("b1 we", 32'(bus.write_enable), 1);
        cyc(1, 0, 0); chk("b2 addr", bus.addr_out, 32'h0C1C); chk("b2 we", 32'(bus.write_enable), 1);
        cyc(1, 0, 0); chk("b3 addr", bus.addr_out, 32'h122A); chk("b3 we", 32'(bus.write_enable), 1);
        cyc(0, 0, 0); chk("b end we", 32'(bus.write_enable), 0);
`else
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        chk("fill full", 32'(bus.full), 1);
        chk("fill rd", bus.rd_addr_out, 32'h060E);
        cyc(1, 0, 0);
        chk("ow we", 32'(bus.write_enable), 1);
        chk("ow addr", bus.addr_out, 32'h060E);
        chk("ow rd", bus.rd_addr_out, 32'h0C1C);
        chk("ow cnt", 32'(bus.slot_count), 4);
        chk("ow ovf", 32'(bus.overflow), 1);
        cyc(0, 0, 0);
`endif

        do_reset();
        cyc(1, 0, 0); chk("pre-rst we", 32'(bus.write_enable), 1);
        rst = 1'b1;
        cyc(1, 0, 0);
        rst = 1'b0;
        chk("mid rst addr", bus.addr_out, 32'h0000);
        chk("mid rst we", 32'(bus.write_enable), 0);
        chk("mid rst rd", bus.rd_addr_out, 32'h060E);
        chk("mid rst empty", 32'(bus.empty), 1);

        for (int k = 0; k < 3000; k++) begin
            int pi, pr;
            pi = (k < 1500) ? 65 : 35;
            pr = (k < 1500) ? 35 : 65;
            rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 99) < pi, $urandom_range(0, 99) < pr,
                $urandom_range(0, 99) < 10);
        end
        rst = 1'b0;
        cyc(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
